// File: rtl/punch_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : punch_detector_if
// Description : Button/mole inputs and judge outputs of the punch detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface punch_detector_if #(
    parameter int N_HOLES = 3,
    parameter int SCORE_W = 8,
    parameter int IDX_W   = (N_HOLES > 1) ? $clog2(N_HOLES) : 1
);
    logic [N_HOLES-1:0] btn;
    logic [N_HOLES-1:0] mole;
    logic               mole_valid;
    logic               initial_;
    logic               need_random;
    logic               shift;
    logic               hit;
    logic               miss;
    logic [IDX_W-1:0]   hit_idx;
    logic [SCORE_W-1:0] score;

    modport master (
        output btn, mole, mole_valid, initial_,
        input  need_random, shift, hit, miss, hit_idx, score
    );

    modport slave (
        input  btn, mole, mole_valid, initial_,
        output need_random, shift, hit, miss, hit_idx, score
    );
endinterface
`default_nettype wire

// File: rtl/punch_detector.sv
`default_nettype none
// ============================================================================
// Module      : punch_detector
// Description : Debounces N buttons and judges presses against the mole mask.
// Revision    : 1.0 - initial release
// ============================================================================
module punch_detector #(
    parameter int N_HOLES    = 3,
    parameter int DEB_CYCLES = 4,
    parameter int SCORE_W    = 8,
    parameter int IDX_W      = (N_HOLES > 1) ? $clog2(N_HOLES) : 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    punch_detector_if.slave bus
);
    localparam int                 c_CNT_W     = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DEB_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

    logic [N_HOLES-1:0] w_deb;
    logic [N_HOLES-1:0] r_deb_q;
    logic [N_HOLES-1:0] w_press;
    logic [N_HOLES-1:0] w_hits;
    logic [IDX_W-1:0]   w_hit_idx;

    generate
        for (genvar g = 0; g < N_HOLES; g++) begin : g_chan
            logic               r_sync1;
            logic               r_sync2;
            logic               r_level;
            logic [c_CNT_W-1:0] r_cnt;

            // The level flips on the DEB_CYCLES-th consecutive mismatching cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= bus.btn[g];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end

            assign w_deb[g] = r_level;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_q <= '0;
        end else begin
            r_deb_q <= w_deb;
        end
    end

    assign w_press = w_deb & ~r_deb_q;
    assign w_hits  = w_press & bus.mole;

    always_comb begin
        w_hit_idx = '0;
        for (int i = N_HOLES - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ARMED = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_need;
    logic               r_hit;
    logic               r_miss;
    logic [IDX_W-1:0]   r_hit_idx;
    logic [SCORE_W-1:0] r_score;

    // Pulses are registered on the transition, so the START pulse is visible during START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_need    <= 1'b0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_hit_idx <= '0;
            r_score   <= '0;
        end else begin
            r_need <= 1'b0;
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            if (bus.initial_) begin
                r_state <= S_START;
                r_need  <= 1'b1;
                r_score <= '0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_START: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (bus.mole_valid) begin
                            r_state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (w_hits != '0) begin
                            r_hit     <= 1'b1;
                            r_need    <= 1'b1;
                            r_hit_idx <= w_hit_idx;
                            if (r_score != c_SCORE_MAX) begin
                                r_score <= r_score + SCORE_W'(1);
                            end
                            r_state <= S_WAIT;
                        end else if (!bus.mole_valid) begin
                            r_state <= S_WAIT;
                        end else if (w_press != '0) begin
                            r_miss <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.need_random = r_need;
    assign bus.shift       = r_need;
    assign bus.hit         = r_hit;
    assign bus.miss        = r_miss;
    assign bus.hit_idx     = r_hit_idx;
    assign bus.score       = r_score;
endmodule
`default_nettype wire

// File: tb/tb_punch_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_punch_detector
// Description : Directed table, corner sequences and random run against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_punch_detector;
    localparam int N    = 3;
    localparam int DEB  = 4;
    localparam int SW   = 2;
    localparam int SMAX = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    punch_detector_if #(.N_HOLES(N), .SCORE_W(SW)) bus ();

    punch_detector #(
        .N_HOLES   (N),
        .DEB_CYCLES(DEB),
        .SCORE_W   (SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a button level is accepted once the last DEB synchronised
    // samples (btn seen two edges earlier) all disagree with the accepted level.
    int           m_state;  // 0 idle, 1 start, 2 wait, 3 armed
    logic [N-1:0] m_deb;
    logic [N-1:0] m_deb_q;
    logic [N-1:0] hist[$];
    logic         e_need;
    logic         e_hit;
    logic         e_miss;
    logic [1:0]   e_idx;
    int           e_score;

    task automatic model_reset();
        m_state = 0;
        m_deb   = '0;
        m_deb_q = '0;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
        e_need  = 1'b0;
        e_hit   = 1'b0;
        e_miss  = 1'b0;
        e_idx   = '0;
        e_score = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] press;
        logic [N-1:0] hits;
        logic [N-1:0] new_deb;
        logic [N-1:0] smp;
        bit           flip;
        bit           found;
        press  = m_deb & ~m_deb_q;
        hits   = press & bus.mole;
        e_need = 1'b0;
        e_hit  = 1'b0;
        e_miss = 1'b0;
        if (bus.initial_) begin
            m_state = 1;
            e_need  = 1'b1;
            e_score = 0;
        end else if (m_state == 1) begin
            m_state = 2;
        end else if (m_state == 2) begin
            if (bus.mole_valid) m_state = 3;
        end else if (m_state == 3) begin
            if (hits != 0) begin
                e_hit  = 1'b1;
                e_need = 1'b1;
                found  = 0;
                for (int i = 0; i < N; i++) begin
                    if (hits[i] && !found) begin
                        e_idx = 2'(i);
                        found = 1;
                    end
                end
                e_score = (e_score + 1 > SMAX) ? SMAX : e_score + 1;
                m_state = 2;
            end else if (!bus.mole_valid) begin
                m_state = 2;
            end else if (press != 0) begin
                e_miss = 1'b1;
            end
        end
        new_deb = m_deb;
        for (int c = 0; c < N; c++) begin
            flip = 1;
            for (int j = hist.size() - 1 - DEB; j <= hist.size() - 2; j++) begin
                smp = hist[j];
                if (smp[c] == m_deb[c]) flip = 0;
            end
            if (flip) new_deb[c] = ~m_deb[c];
        end
        hist.push_back(bus.btn);
        if (hist.size() > DEB + 2) void'(hist.pop_front());
        m_deb_q = m_deb;
        m_deb   = new_deb;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {8'd0, bus.need_random, bus.shift, bus.hit, bus.miss, bus.hit_idx, bus.score};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check("cycle_vs_model", outs(),
              {8'd0, e_need, e_need, e_hit, e_miss, e_idx, 2'(e_score)});
    endtask

    typedef struct {
        logic [2:0] mole;
        logic [2:0] btn;
        logic       hit;
        logic       miss;
        logic [1:0] idx;
        logic [1:0] score;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        n_checks = 0;
        n_pass   = 0;
        tbl[0] = '{mole: 3'b010, btn: 3'b010, hit: 1'b1, miss: 1'b0, idx: 2'd1, score: 2'd1};
        tbl[1] = '{mole: 3'b001, btn: 3'b100, hit: 1'b0, miss: 1'b1, idx: 2'd1, score: 2'd1};
        tbl[2] = '{mole: 3'b001, btn: 3'b001, hit: 1'b1, miss: 1'b0, idx: 2'd0, score: 2'd2};
        tbl[3] = '{mole: 3'b100, btn: 3'b101, hit: 1'b1, miss: 1'b0, idx: 2'd2, score: 2'd3};
        tbl[4] = '{mole: 3'b110, btn: 3'b110, hit: 1'b1, miss: 1'b0, idx: 2'd1, score: 2'd3};
        tbl[5] = '{mole: 3'b011, btn: 3'b100, hit: 1'b0, miss: 1'b1, idx: 2'd1, score: 2'd3};
        tbl[6] = '{mole: 3'b111, btn: 3'b111, hit: 1'b1, miss: 1'b0, idx: 2'd0, score: 2'd3};

        rst            = 1'b1;
        bus.btn        = '0;
        bus.mole       = '0;
        bus.mole_valid = 1'b0;
        bus.initial_   = 1'b0;
        model_reset();
        repeat (2) tick();
        check("reset_state", outs(), 16'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_quiet", outs(), 16'd0);

        // Start: one need_random/shift pulse, score 0
        bus.mole_valid = 1'b1;
        bus.initial_   = 1'b1;
        tick();
        check("start_pulse", {14'd0, bus.need_random, bus.shift}, 16'b11);
        check("start_no_hit", {14'd0, bus.hit, bus.miss}, 16'd0);
        bus.initial_ = 1'b0;
        tick();
        check("start_single", {15'd0, bus.need_random}, 16'd0);
        repeat (3) tick();

        for (int v = 0; v < 7; v++) begin
            bus.mole = tbl[v].mole;
            bus.btn  = tbl[v].btn;
            repeat (6) tick();
            check("pre_judge", {13'd0, bus.hit, bus.miss, bus.need_random}, 16'd0);
            tick();
            check("judge", {9'd0, bus.hit, bus.miss, bus.need_random, bus.hit_idx, bus.score},
                  {9'd0, tbl[v].hit, tbl[v].miss, tbl[v].hit, tbl[v].idx, tbl[v].score});
            seen = 1'b0;
            repeat (4) begin
                tick();
                seen = seen | bus.hit | bus.miss;
            end
            check("hold_no_repeat", {15'd0, seen}, 16'd0);
            bus.btn = '0;
            repeat (8) tick();
        end

        // Glitch: three-cycle pulse on btn[0]
        bus.mole = 3'b001;
        bus.btn  = 3'b001;
        repeat (3) tick();
        bus.btn = '0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | bus.hit | bus.miss;
        end
        check("glitch_rejected", {15'd0, seen}, 16'd0);

        // Restart coincident with a hit
        bus.mole = 3'b010;
        bus.btn  = 3'b010;
        repeat (6) tick();
        bus.initial_ = 1'b1;
        tick();
        check("restart_prio", {11'd0, bus.need_random, bus.shift, bus.hit, bus.score},
              {11'd0, 1'b1, 1'b1, 1'b0, 2'd0});
        bus.initial_ = 1'b0;
        bus.btn      = '0;
        repeat (8) tick();

        // Lockout: press during WAIT, then no replay on re-arm
        bus.mole_valid = 1'b0;
        tick();
        bus.mole = 3'b001;
        bus.btn  = 3'b001;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | bus.hit | bus.miss | bus.need_random;
        end
        check("wait_lockout", {15'd0, seen}, 16'd0);
        bus.btn = '0;
        repeat (8) tick();
        bus.btn        = 3'b001;
        repeat (10) tick();
        bus.mole_valid = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | bus.hit | bus.miss;
        end
        check("no_replay", {15'd0, seen}, 16'd0);
        bus.btn = '0;
        repeat (8) tick();

        // Asynchronous reset mid-debounce with the button still held
        bus.mole = 3'b010;
        bus.btn  = 3'b010;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset", outs(), 16'd0);
        repeat (2) tick();
        rst          = 1'b0;
        bus.initial_ = 1'b1;
        tick();
        bus.initial_ = 1'b0;
        repeat (10) tick();
        check("held_after_reset", {14'd0, bus.score}, 16'd1);
        bus.btn = '0;
        repeat (8) tick();

        // Random run against the model
        bus.initial_ = 1'b1;
        tick();
        bus.initial_ = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) bus.btn[b] = ~bus.btn[b];
            end
            if ($urandom_range(0, 19) == 0) bus.mole = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) bus.mole_valid = ~bus.mole_valid;
            bus.initial_ = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
